// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and index helpers for the stream multiplexer
// Purpose: FSM state type and modulo channel-index wrap used by the mux and arbiter.
// Ports: none (package).
package mux_pkg;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  // Wraps an index into [0, n). Callers only ever pass idx < 2*n, so a single
  // conditional subtract is enough and works for non-power-of-2 channel counts.
  function automatic int unsigned ch_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority find-first arbiter
// Purpose: picks the first requesting channel after ptr, scanning ptr+1, ptr+2, ... modulo NUM_CH.
// Ports:
//   req     in   NUM_CH  per-channel request
//   ptr     in   SEL_W   last served channel; it gets lowest priority
//   gnt_idx out  SEL_W   granted channel index (0 when nothing granted)
//   gnt_vld out  1       at least one request present
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = SEL_W'(ch_wrap(32'(ptr) + 32'(k) + 32'd1, 32'(NUM_CH)));
      if (!gnt_vld && req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N:1 stream mux with fixed or round-robin select and packet lock
// Purpose: merges NUM_CH valid/ready channels onto one registered output stream; a packet,
//          once started, holds the grant until its last beat is accepted.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   mode        0 = fixed select via sel, 1 = round-robin
//   sel         channel index used in fixed mode
//   in_valid / in_last / in_data   per-channel beat, channel i at [i*WIDTH +: WIDTH]
//   in_ready    per-channel accept (combinational, one-hot or zero)
//   out_valid / out_data / out_last / out_ch   registered output beat and its source channel
//   out_ready   downstream accept
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] NUM_CH_X = (SEL_W+1)'(NUM_CH);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] grant;
  logic             granted;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] grant_data;
  logic             grant_last;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Single-stage pipeline: the register can take a new beat when empty or draining.
  assign load_en = !out_valid || out_ready;

  // Mode and sel only matter between packets; a locked packet owns the grant.
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    if (state == ST_LOCKED) begin
      grant   = lock_ch;
      granted = 1'b1;
    end else if (mode) begin
      grant   = arb_idx;
      granted = arb_vld;
    end else if ({1'b0, sel} < NUM_CH_X) begin
      grant   = sel;
      granted = 1'b1;
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    grant_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        grant_last  = in_last[i];
        in_ready[i] = load_en && granted;
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      state     <= ST_IDLE;
      lock_ch   <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (load_en) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_last  <= grant_last;
        out_ch    <= grant;
        if (grant_last) begin
          rr_ptr <= grant;
          state  <= ST_IDLE;
        end else if (state == ST_IDLE) begin
          state   <= ST_LOCKED;
          lock_ch <= grant;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a packet-level model
module tb_stream_mux_rr;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_last = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b1;

  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = 2'd3;
  logic [2:0]  in_valid3 = 3'b111;
  logic [2:0]  in_last3 = 3'b111;
  logic [23:0] in_data3 = 24'h5C_3B_2A;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic        out_last3;
  logic [1:0]  out_ch3;
  logic        out_ready3 = 1'b1;

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.NUM_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_last(in_last3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  int checks = 0;
  int errors = 0;

  // Reference: what the output register holds, whether a packet owns the mux, who was served last.
  bit       m_valid, m_last, m_locked;
  bit [7:0] m_data;
  int       m_ch, m_ptr, m_lock_ch;
  bit       m_acc;
  int       m_acc_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_last = 0; m_ch = 0;
    m_locked = 0; m_lock_ch = 0; m_ptr = NUM_CH - 1;
  endtask

  // One clock: compare DUT to the model at the falling edge, then advance the model.
  task automatic cycle();
    int       g;
    bit       gv, room, acc, lst;
    bit [7:0] d;
    bit [3:0] er;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_last",  32'(out_last),  32'(m_last));
    check("out_ch",    32'(out_ch),    32'(m_ch));
    room = !m_valid || out_ready;
    gv = 0; g = 0;
    if (m_locked) begin
      gv = 1; g = m_lock_ch;
    end else if (!mode) begin
      if (int'(sel) < NUM_CH) begin gv = 1; g = int'(sel); end
    end else begin
      for (int k = 1; k <= NUM_CH; k++)
        if (!gv && in_valid[(m_ptr + k) % NUM_CH]) begin gv = 1; g = (m_ptr + k) % NUM_CH; end
    end
    er = (room && gv) ? 4'(1 << g) : 4'd0;
    check("in_ready", 32'(in_ready), 32'(er));
    acc = room && gv && in_valid[g];
    d   = in_data[g*WIDTH +: WIDTH];
    lst = in_last[g];
    m_acc = 0;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else if (room) begin
      if (acc) begin
        m_acc = 1; m_acc_ch = g;
        m_valid = 1; m_data = d; m_last = lst; m_ch = g;
        if (lst) begin
          m_locked = 0; m_ptr = g;
        end else if (!m_locked) begin
          m_locked = 1; m_lock_ch = g;
        end
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int      ch1_cnt;
    bit [7:0] held;

    // Bring both DUTs to a defined state before the model starts comparing.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Fixed select: ch2 sends three single-beat packets.
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    in_valid = 4'b0100; in_last = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      in_data[16 +: 8] = 8'hA1 + 8'(k);
      cycle();
      check("t1_ready_others", 32'(in_ready & 4'b1011), 32'd0);
    end
    check("t1_last_data", 32'(out_data), 32'hA3);
    check("t1_out_ch", 32'(out_ch), 32'd2);
    in_valid = 4'b0000;
    cycle();

    // Round robin with everyone valid: strict 0,1,2,3,... rotation with no bubbles.
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      in_data = $urandom;
      cycle();
      check("t2_rr_ch", 32'(out_ch), 32'(k % 4));
      check("t2_rr_valid", 32'(out_valid), 32'd1);
    end

    // Packet lock: ch1 3-beat packet while ch0 and ch2 keep requesting.
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_last = 4'b0001;
    cycle();
    in_valid = 4'b0111; in_last = 4'b0101; ch1_cnt = 0;
    for (int k = 0; k < 10 && ch1_cnt < 3; k++) begin
      in_last[1] = (ch1_cnt == 2);
      if (k == 1) sel = 2'd3;
      in_data = $urandom;
      cycle();
      if (m_acc && m_acc_ch == 1) ch1_cnt++;
    end
    check("t3_ch1_beats", 32'(ch1_cnt), 32'd3);
    in_data = $urandom;
    cycle();
    check("t3_next_ch", 32'(out_ch), 32'd2);

    // Backpressure: output register holds and nothing is accepted.
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b0;
    held = out_data;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      cycle();
      check("t4_hold_data", 32'(out_data), 32'(held));
      check("t4_no_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data = $urandom; cycle(); end

    // Reset in the middle of a ch3 packet.
    do_reset();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; in_last = 4'b0000;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t5_valid_after_reset", 32'(out_valid), 32'd0);
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    cycle();
    check("t5_first_ch0", 32'(out_ch), 32'd0);

    // Out-of-range fixed select on a 3-channel instance, then an in-range one.
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_no_ready", 32'(in_ready3), 32'd0);
      check("t6_no_valid", 32'(out_valid3), 32'd0);
    end
    sel3 = 2'd2;
    #1;
    check("t6_sel2_ready", 32'(in_ready3), 32'b100);
    cycle();
    check("t6_sel2_valid", 32'(out_valid3), 32'd1);
    check("t6_sel2_data", 32'(out_data3), 32'h5C);
    check("t6_sel2_ch", 32'(out_ch3), 32'd2);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if (k % 8 == 0) begin
        mode = 1'($urandom);
        sel  = 2'($urandom);
      end
      in_valid  = 4'($urandom);
      in_last   = {($urandom_range(2) == 0), ($urandom_range(2) == 0),
                   ($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
      reset     = ($urandom_range(199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
